// File: rtl/spi_sclk_gen_pkg.sv
// Shared constants for the SPI master clock/transfer controller:
// operating-mode codes, FSM state encoding and default widths.
package spi_sclk_gen_pkg;

    localparam int DIV_W_DEFAULT     = 12;
    localparam int DATA_BITS_DEFAULT = 8;

    localparam logic [1:0] SPI_RUN  = 2'b00;
    localparam logic [1:0] SPI_WAIT = 2'b01;
    localparam logic [1:0] SPI_STOP = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } spi_state_t;

    // SCLK generation runs in RUN mode, and in WAIT mode only when
    // stop-in-wait is not requested; STOP and the reserved code halt it.
    function automatic logic clock_enabled(input logic [1:0] mode, input logic swai);
        logic en;
        case (mode)
            SPI_RUN:  en = 1'b1;
            SPI_WAIT: en = ~swai;
            SPI_STOP: en = 1'b0;
            default:  en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/spi_sclk_gen_if.sv
// Register-interface side of the SPI clock generator: control inputs from
// the APB block and status/strobe outputs towards it and the shift register.
interface spi_sclk_gen_if #(
    parameter int DIV_W = spi_sclk_gen_pkg::DIV_W_DEFAULT
);
    logic             send_data;
    logic             mstr;
    logic             cpol;
    logic             cpha;
    logic             spiswai;
    logic [1:0]       spi_mode;
    logic [2:0]       sppr;
    logic [2:0]       spr;

    logic             sclk;
    logic             ss;
    logic             tip;
    logic             receive_data;
    logic             mosi_send_strobe;
    logic             miso_sample_strobe;
    logic [DIV_W-1:0] baud_rate_divisor;

    // Register block / stimulus side
    modport master (
        output send_data, mstr, cpol, cpha, spiswai, spi_mode, sppr, spr,
        input  sclk, ss, tip, receive_data, mosi_send_strobe, miso_sample_strobe,
               baud_rate_divisor
    );

    // Clock generator side
    modport slave (
        input  send_data, mstr, cpol, cpha, spiswai, spi_mode, sppr, spr,
        output sclk, ss, tip, receive_data, mosi_send_strobe, miso_sample_strobe,
               baud_rate_divisor
    );
endinterface

// File: rtl/spi_half_period_counter.sv
// Counts clock cycles within one SCLK half-period and flags the last one.
// wrap is high during the cycle whose count equals half-1 while enabled,
// so the edge that ends it is the edge at which SCLK changes.
module spi_half_period_counter #(
    parameter int CNT_W = 11
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] half,
    output logic             wrap
);
    logic [CNT_W-1:0] count_reg;

    assign wrap = enable && !clear && (count_reg == half - CNT_W'(1));

    // Free-running count, held while disabled, restarted on wrap or clear
    always_ff @(posedge PCLK) begin
        if (PRESET || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= wrap ? '0 : count_reg + CNT_W'(1);
        end
    end
endmodule

// File: rtl/spi_sclk_gen.sv
// SPI master clock and transfer controller. Produces SCLK at the programmed
// baud rate, frames one DATA_BITS transfer under an active-low slave select
// and emits registered shift/sample strobes aligned with each SCLK edge.
module spi_sclk_gen
    import spi_sclk_gen_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT,
    parameter int DIV_W     = DIV_W_DEFAULT
) (
    input  logic           PCLK,
    input  logic           PRESET,
    spi_sclk_gen_if.slave  bus
);
    localparam int CNT_W  = DIV_W - 1;
    localparam int HALVES = 2 * DATA_BITS;
    localparam int H_W    = $clog2(HALVES);
    localparam logic [H_W-1:0] LAST_HALF = H_W'(HALVES - 1);

    spi_state_t       state_reg;
    logic             sclk_reg;
    logic             ss_reg;
    logic             tip_reg;
    logic             receive_reg;
    logic             mosi_reg;
    logic             miso_reg;
    logic [H_W-1:0]   h_reg;
    logic             cpol_reg;
    logic             cpha_reg;
    logic [2:0]       sppr_reg;
    logic [2:0]       spr_reg;

    logic             clk_en;
    logic             cnt_enable;
    logic             cnt_clear;
    logic             wrap;
    logic             leading;
    logic             last_half;
    logic [CNT_W-1:0] half;

    // Divisor follows the live register fields, even mid-transfer
    assign bus.baud_rate_divisor = ((DIV_W'(bus.sppr) + DIV_W'(1)) << bus.spr) << 1;

    // Half-period uses the fields captured at transfer start
    assign half = (CNT_W'(sppr_reg) + CNT_W'(1)) << spr_reg;

    assign clk_en     = clock_enabled(bus.spi_mode, bus.spiswai);
    assign cnt_enable = (state_reg == ST_XFER) && bus.mstr && clk_en;
    assign cnt_clear  = (state_reg == ST_IDLE);
    assign leading    = ~h_reg[0];
    assign last_half  = (h_reg == LAST_HALF);

    spi_half_period_counter #(
        .CNT_W (CNT_W)
    ) u_half_cnt (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .enable (cnt_enable),
        .clear  (cnt_clear),
        .half   (half),
        .wrap   (wrap)
    );

    // Transfer FSM: SCLK toggling, half index, framing and strobe decode
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg   <= ST_IDLE;
            sclk_reg    <= bus.cpol;
            ss_reg      <= 1'b1;
            tip_reg     <= 1'b0;
            receive_reg <= 1'b0;
            mosi_reg    <= 1'b0;
            miso_reg    <= 1'b0;
            h_reg       <= '0;
            cpol_reg    <= bus.cpol;
            cpha_reg    <= 1'b0;
            sppr_reg    <= '0;
            spr_reg     <= '0;
        end else begin
            receive_reg <= 1'b0;
            mosi_reg    <= 1'b0;
            miso_reg    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    sclk_reg <= bus.cpol;
                    ss_reg   <= 1'b1;
                    tip_reg  <= 1'b0;
                    h_reg    <= '0;
                    if (bus.send_data && bus.mstr && clk_en) begin
                        state_reg <= ST_XFER;
                        cpol_reg  <= bus.cpol;
                        cpha_reg  <= bus.cpha;
                        sppr_reg  <= bus.sppr;
                        spr_reg   <= bus.spr;
                        ss_reg    <= 1'b0;
                        tip_reg   <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (!bus.mstr) begin
                        // Master disabled: drop the frame silently
                        state_reg <= ST_IDLE;
                        sclk_reg  <= cpol_reg;
                        ss_reg    <= 1'b1;
                        tip_reg   <= 1'b0;
                        h_reg     <= '0;
                    end else if (wrap) begin
                        if (last_half) begin
                            state_reg   <= ST_IDLE;
                            sclk_reg    <= cpol_reg;
                            ss_reg      <= 1'b1;
                            tip_reg     <= 1'b0;
                            receive_reg <= 1'b1;
                            h_reg       <= '0;
                        end else begin
                            sclk_reg <= ~sclk_reg;
                            h_reg    <= h_reg + H_W'(1);
                        end
                        // With cpha=0 the first bit is already on the line
                        // when ss falls, so the final trailing edge shifts nothing.
                        if (cpha_reg) begin
                            mosi_reg <= leading;
                            miso_reg <= ~leading;
                        end else begin
                            miso_reg <= leading;
                            mosi_reg <= ~leading && !last_half;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.sclk               = sclk_reg;
    assign bus.ss                 = ss_reg;
    assign bus.tip                = tip_reg;
    assign bus.receive_data       = receive_reg;
    assign bus.mosi_send_strobe   = mosi_reg;
    assign bus.miso_sample_strobe = miso_reg;
endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: divisor table, table-driven
// transfers, abort/reset sequences and randomized transfers compared
// cycle by cycle against an arithmetic model of the SCLK waveform.
`timescale 1ns/1ps
module tb_spi_sclk_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_sclk_gen_if #(.DIV_W(12)) bus();

    spi_sclk_gen #(.DATA_BITS(8), .DIV_W(12)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [2:0] sppr;
        logic [2:0] spr;
        int         fs;
        int         fl;
        int         exp_tip;
        int         exp_mosi;
        int         exp_miso;
    } xfer_vec_t;

    typedef struct {
        logic [2:0] sppr;
        logic [2:0] spr;
        int         exp_div;
    } div_vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel 0/1: clock enabled (run, or wait without stop-in-wait)
    // sel 2/3/4: clock disabled (wait+swai, stop, reserved)
    task automatic drive_mode(input int sel);
        case (sel)
            0: begin bus.spi_mode = 2'b00; bus.spiswai = 1'($urandom_range(0, 1)); end
            1: begin bus.spi_mode = 2'b01; bus.spiswai = 1'b0; end
            2: begin bus.spi_mode = 2'b01; bus.spiswai = 1'b1; end
            3: begin bus.spi_mode = 2'b10; bus.spiswai = 1'($urandom_range(0, 1)); end
            default: begin bus.spi_mode = 2'b11; bus.spiswai = 1'($urandom_range(0, 1)); end
        endcase
    endtask

    // Expected {sclk, ss, tip, receive, mosi, miso} after n enabled edges
    // into a transfer with half-period hp; edge_en says whether the edge
    // just taken advanced the transfer.
    function automatic logic [5:0] model(input logic c_pol, input logic c_pha,
                                         input int hp, input int n, input bit edge_en);
        logic sclk_e, ss_e, tip_e, rd_e, mosi_e, miso_e;
        int   hh;
        bit   lead;
        if (n < 16 * hp) begin
            tip_e  = 1'b1;
            ss_e   = 1'b0;
            sclk_e = c_pol ^ 1'((n / hp) % 2);
            rd_e   = 1'b0;
        end else begin
            tip_e  = 1'b0;
            ss_e   = 1'b1;
            sclk_e = c_pol;
            rd_e   = edge_en;
        end
        mosi_e = 1'b0;
        miso_e = 1'b0;
        if (edge_en && n > 0 && (n % hp) == 0) begin
            hh   = n / hp - 1;
            lead = (hh % 2) == 0;
            if (c_pha) begin
                mosi_e = lead;
                miso_e = !lead;
            end else begin
                miso_e = lead;
                mosi_e = !lead && (hh != 15);
            end
        end
        return {sclk_e, ss_e, tip_e, rd_e, mosi_e, miso_e};
    endfunction

    function automatic logic [5:0] observe();
        return {bus.sclk, bus.ss, bus.tip, bus.receive_data,
                bus.mosi_send_strobe, bus.miso_sample_strobe};
    endfunction

    // Runs one transfer, freezing the clock for fl edges starting after
    // observation fs, and compares every cycle with the model.
    task automatic run_xfer(input logic c_pol, input logic c_pha,
                            input logic [2:0] p, input logic [2:0] s,
                            input int fs, input int fl, input int fsel, input bit scramble,
                            output int tip_len, output int n_mosi, output int n_miso,
                            output int n_rd);
        int         hp, total, n, k, limit, trace_err, bad_k;
        bit         en;
        logic [5:0] exp_v, act_v, bad_e, bad_a;
        hp        = (int'(p) + 1) << s;
        total     = 16 * hp;
        limit     = total + fl + 8;
        n         = 0;
        k         = 0;
        trace_err = 0;
        bad_k     = -1;
        bad_e     = '0;
        bad_a     = '0;
        tip_len   = 0;
        n_mosi    = 0;
        n_miso    = 0;
        n_rd      = 0;
        en        = 1'b0;

        bus.cpol      = c_pol;
        bus.cpha      = c_pha;
        bus.sppr      = p;
        bus.spr       = s;
        bus.mstr      = 1'b1;
        drive_mode($urandom_range(0, 1));
        bus.send_data = 1'b1;
        tick();
        bus.send_data = 1'b0;

        while (1) begin
            exp_v = model(c_pol, c_pha, hp, n, en);
            act_v = observe();
            tip_len += int'(act_v[3]);
            n_rd    += int'(act_v[2]);
            n_mosi  += int'(act_v[1]);
            n_miso  += int'(act_v[0]);
            if (act_v !== exp_v) begin
                trace_err++;
                if (bad_k < 0) begin bad_k = k; bad_e = exp_v; bad_a = act_v; end
            end
            if (n >= total || k >= limit) break;
            if (k >= fs && k < fs + fl) begin
                drive_mode(fsel);
                en = 1'b0;
            end else begin
                drive_mode($urandom_range(0, 1));
                en = 1'b1;
            end
            bus.send_data = 1'b0;
            if (scramble) begin
                bus.cpol      = 1'($urandom);
                bus.cpha      = 1'($urandom);
                bus.sppr      = 3'($urandom);
                bus.spr       = 3'($urandom);
                bus.send_data = ($urandom_range(0, 7) == 0);
            end
            // a request on the completion edge must be ignored
            if (en && n == total - 1) bus.send_data = 1'b1;
            tick();
            k++;
            if (en) n++;
        end
        if (n < total) begin
            trace_err++;
            if (bad_k < 0) bad_k = k;
        end

        // one idle cycle after completion: nothing restarts
        bus.send_data = 1'b0;
        bus.cpol      = c_pol;
        drive_mode(0);
        tick();
        exp_v = {c_pol, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        act_v = observe();
        tip_len += int'(act_v[3]);
        n_rd    += int'(act_v[2]);
        n_mosi  += int'(act_v[1]);
        n_miso  += int'(act_v[0]);
        if (act_v !== exp_v) begin
            trace_err++;
            if (bad_k < 0) begin bad_k = k + 1; bad_e = exp_v; bad_a = act_v; end
        end

        n_cmp++;
        if (trace_err != 0) begin
            n_fail++;
            $display("FAIL trace: %0d bad cycles, first at cycle %0d got %b expected %b (sclk,ss,tip,rd,mosi,miso)",
                     trace_err, bad_k, bad_a, bad_e);
        end
        $display("xfer cpol=%0d cpha=%0d H=%0d freeze=%0d tip_len=%0d send=%0d sample=%0d rd=%0d",
                 c_pol, c_pha, hp, fl, tip_len, n_mosi, n_miso, n_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        xfer_vec_t vecs[5];
        div_vec_t  divs[6];
        int        tl, nm, ns, nr, hp, fl, fs, acc_rd, acc_tip;
        logic      c_pol, c_pha;
        logic [2:0] p, s;

        vecs[0] = '{1'b0, 1'b0, 3'd0, 3'd0, 0, 0,  16,    7, 8};
        vecs[1] = '{1'b1, 1'b1, 3'd2, 3'd1, 0, 0,  96,    8, 8};
        vecs[2] = '{1'b0, 1'b0, 3'd7, 3'd7, 0, 0,  16384, 7, 8};
        vecs[3] = '{1'b0, 1'b1, 3'd1, 3'd0, 5, 10, 42,    8, 8};
        vecs[4] = '{1'b1, 1'b0, 3'd0, 3'd0, 3, 10, 26,    7, 8};

        divs[0] = '{3'd0, 3'd0, 2};
        divs[1] = '{3'd2, 3'd1, 12};
        divs[2] = '{3'd7, 3'd7, 2048};
        divs[3] = '{3'd0, 3'd7, 256};
        divs[4] = '{3'd7, 3'd0, 16};
        divs[5] = '{3'd3, 3'd2, 32};

        rst           = 1'b1;
        bus.send_data = 1'b0;
        bus.mstr      = 1'b0;
        bus.cpol      = 1'b1;
        bus.cpha      = 1'b0;
        bus.spiswai   = 1'b0;
        bus.spi_mode  = 2'b00;
        bus.sppr      = 3'd0;
        bus.spr       = 3'd0;
        tick();
        tick();
        check("reset_sclk", int'(bus.sclk), 1);
        check("reset_ss", int'(bus.ss), 1);
        check("reset_tip", int'(bus.tip), 0);
        check("reset_rd", int'(bus.receive_data), 0);
        check("reset_mosi", int'(bus.mosi_send_strobe), 0);
        check("reset_miso", int'(bus.miso_sample_strobe), 0);
        rst = 1'b0;

        bus.cpol = 1'b0;
        tick();
        check("idle_sclk_tracks_cpol", int'(bus.sclk), 0);

        foreach (divs[i]) begin
            bus.sppr = divs[i].sppr;
            bus.spr  = divs[i].spr;
            #1;
            check($sformatf("divisor[%0d]", i), int'(bus.baud_rate_divisor), divs[i].exp_div);
        end

        foreach (vecs[i]) begin
            run_xfer(vecs[i].cpol, vecs[i].cpha, vecs[i].sppr, vecs[i].spr,
                     vecs[i].fs, vecs[i].fl, 2, 1'b0, tl, nm, ns, nr);
            check($sformatf("vec%0d_tip_len", i), tl, vecs[i].exp_tip);
            check($sformatf("vec%0d_send", i), nm, vecs[i].exp_mosi);
            check($sformatf("vec%0d_sample", i), ns, vecs[i].exp_miso);
            check($sformatf("vec%0d_rd", i), nr, 1);
        end

        // abort by clearing mstr mid-transfer
        bus.cpol = 1'b1; bus.cpha = 1'b0; bus.sppr = 3'd1; bus.spr = 3'd0;
        bus.mstr = 1'b1; drive_mode(0); bus.send_data = 1'b1;
        tick();
        bus.send_data = 1'b0;
        repeat (7) tick();
        check("abort_pre_tip", int'(bus.tip), 1);
        bus.mstr = 1'b0;
        tick();
        check("abort_ss", int'(bus.ss), 1);
        check("abort_tip", int'(bus.tip), 0);
        check("abort_sclk", int'(bus.sclk), 1);
        check("abort_strobes", int'(bus.mosi_send_strobe | bus.miso_sample_strobe), 0);
        acc_rd = int'(bus.receive_data);
        acc_tip = 0;
        repeat (20) begin
            tick();
            acc_rd  += int'(bus.receive_data);
            acc_tip += int'(bus.tip);
        end
        check("abort_no_rd", acc_rd, 0);
        check("abort_stays_idle", acc_tip, 0);
        run_xfer(1'b0, 1'b0, 3'd0, 3'd1, 0, 0, 2, 1'b0, tl, nm, ns, nr);
        check("after_abort_tip_len", tl, 32);
        check("after_abort_rd", nr, 1);

        // synchronous reset mid-transfer with an extra request during tip
        bus.cpol = 1'b0; bus.cpha = 1'b1; bus.sppr = 3'd3; bus.spr = 3'd0;
        bus.mstr = 1'b1; drive_mode(0); bus.send_data = 1'b1;
        tick();
        bus.send_data = 1'b0;
        repeat (5) tick();
        bus.send_data = 1'b1;
        tick();
        bus.send_data = 1'b0;
        check("busy_request_tip", int'(bus.tip), 1);
        bus.cpol = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_sclk", int'(bus.sclk), 1);
        check("midreset_ss", int'(bus.ss), 1);
        check("midreset_tip", int'(bus.tip), 0);
        check("midreset_outs", int'({bus.receive_data, bus.mosi_send_strobe, bus.miso_sample_strobe}), 0);
        acc_rd = 0;
        acc_tip = 0;
        repeat (80) begin
            tick();
            acc_rd  += int'(bus.receive_data);
            acc_tip += int'(bus.tip);
        end
        check("midreset_no_rd", acc_rd, 0);
        check("midreset_no_second_xfer", acc_tip, 0);

        // randomized transfers with live-field scrambling and clock freezes
        for (int r = 0; r < 20; r++) begin
            c_pol = 1'($urandom);
            c_pha = 1'($urandom);
            p     = 3'($urandom_range(0, 3));
            s     = 3'($urandom_range(0, 3));
            hp    = (int'(p) + 1) << s;
            fl    = $urandom_range(0, 12);
            fs    = $urandom_range(0, 16 * hp - 1);
            run_xfer(c_pol, c_pha, p, s, fs, fl, $urandom_range(2, 4), 1'b1, tl, nm, ns, nr);
            check($sformatf("rand%0d_tip_len", r), tl, 16 * hp + fl);
            check($sformatf("rand%0d_send", r), nm, c_pha ? 8 : 7);
            check($sformatf("rand%0d_sample", r), ns, 8);
            check($sformatf("rand%0d_rd", r), nr, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
- Master-side SPI clock and transfer controller, directly downstream of the APB register interface.
- Consumes these register-interface outputs: send_data, mstr, cpol, cpha, spiswai, spi_mode, sppr, spr.
- Generates SCLK at the programmed baud rate, drives the slave select, frames one 8-bit transfer, and emits per-edge shift/sample strobes for the data shift register.
- Reports transfer-in-progress (tip) and completion (receive_data) back to the register interface.

Parameters:
- DATA_BITS, 8, bits per transfer; one transfer = 2*DATA_BITS SCLK half-periods.
- DIV_W, 12, width of baud_rate_divisor; must hold 2048.

Ports:
- PCLK  in  1  system clock; all logic on rising edge.
- PRESET  in  1  synchronous reset, active-high.
- send_data  in  1  single-cycle transfer request.
- mstr  in  1  master enable; 0 = block idle, aborts any transfer.
- cpol  in  1  SCLK idle level.
- cpha  in  1  clock phase.
- spiswai  in  1  stop-in-wait enable.
- spi_mode  in  2  00 run, 01 wait, 10 stop.
- sppr  in  3  baud prescaler select.
- spr  in  3  baud rate select.
- sclk  out  1  SPI serial clock.
- ss  out  1  slave select, active-low.
- tip  out  1  transfer in progress.
- receive_data  out  1  one-cycle pulse on normal transfer completion.
- mosi_send_strobe  out  1  one-cycle pulse: shift register presents next TX bit.
- miso_sample_strobe  out  1  one-cycle pulse: shift register samples MISO.
- baud_rate_divisor  out  DIV_W  current divisor value, combinational from sppr/spr.

Behaviour:
- Reset (PRESET=1 at a clock edge):
  - sclk=cpol as sampled that cycle, ss=1, tip=0.
  - receive_data, mosi_send_strobe, miso_sample_strobe = 0.
  - Half-period counter and half index cleared; FSM to IDLE.
  - Reset mid-transfer aborts with no receive_data pulse.
- Divisor:
  - baud_rate_divisor = (sppr+1) << (spr+1); range 2..2048.
  - Half-period H = (sppr+1) << spr.
- FSM states: IDLE, XFER.
- IDLE:
  - ss=1, tip=0, sclk tracks live cpol.
  - Go to XFER when send_data=1, mstr=1, and the clock is enabled.
  - On entry, latch cpol, cpha, sppr, spr, clear counter and half index h.
  - Next cycle: ss=0, tip=1.
- Clock enable:
  - Enabled when spi_mode==00, or spi_mode==01 with spiswai=0.
  - Disabled otherwise (01 with spiswai=1, 10, or 11).
  - While disabled in XFER: counter, h, sclk and ss freeze; no strobes. Resume exactly where frozen.
- XFER half-periods:
  - Counter runs 0..H-1.
  - At count H-1: counter wraps to 0, h increments, sclk toggles (except after the final half-period).
  - Edge ending half h is a leading edge if h is even, trailing if h is odd.
- Strobes are registered and high in the same cycle sclk shows its new level.
- cpha=0:
  - miso_sample_strobe on leading edges (8).
  - mosi_send_strobe on trailing edges h=1,3,..,13 (7). The first bit is already presented when ss falls.
- cpha=1:
  - mosi_send_strobe on leading edges (8).
  - miso_sample_strobe on trailing edges (8).
- Completion:
  - At the end of h=2*DATA_BITS-1, sclk returns to latched cpol, ss=1, tip=0, receive_data=1 for one cycle, FSM to IDLE.
  - tip is high for exactly 16*H enabled cycles.
- Boundaries:
  - send_data during XFER or on the completion cycle is ignored.
  - mstr=0 in XFER aborts within one cycle: ss=1, tip=0, sclk=cpol, no receive_data, no strobes.
  - sppr/spr/cpol/cpha changes during XFER are ignored (latched values used); baud_rate_divisor still tracks live inputs.
  - H=1 (sppr=0, spr=0): sclk toggles every cycle and strobes may be high on consecutive cycles.

Decomposition:
- spi_pkg holds:
  - mode constants SPI_RUN=2'b00, SPI_WAIT=2'b01, SPI_STOP=2'b10;
  - FSM state encoding;
  - DIV_W default.
- One sub-module is natural: spi_half_period_counter.
  - Inputs: PCLK, PRESET, enable, clear, latched H.
  - Output: one-cycle wrap pulse at count H-1.
- FSM, sclk toggle, h counter and strobe decode stay in spi_sclk_gen.

Test Plan:
- sppr=0, spr=0, cpol=0, cpha=0, mode=00, send_data pulse -> divisor=2; tip high 16 cycles; sclk toggles every cycle; 8 sample and 7 send strobes; receive_data one pulse; ss low for 16 cycles.
- sppr=2, spr=1, cpol=1, cpha=1 -> divisor=12, H=6; sclk idles 1; tip high 96 cycles; 8 send strobes on falling sclk, 8 sample strobes on rising sclk.
- sppr=7, spr=7 -> divisor=2048; first sclk edge 1024 cycles after ss falls; tip high 16384 cycles.
- Mid-transfer, set spi_mode=01 with spiswai=1 for 10 cycles -> sclk/ss/counter frozen, no strobes; tip length extended by exactly 10 cycles; spiswai=0 resumes.
- Mid-transfer, mstr=0 -> next cycle ss=1, tip=0, sclk=cpol, receive_data never asserted; later send_data with mstr=1 starts a clean transfer.
- PRESET=1 mid-transfer, plus send_data while tip=1 -> reset returns all outputs to reset values the following cycle; the extra send_data produces no second transfer.
